// File: rtl/seg_scroll_ctrl.sv
// Buffers active-low 7-segment patterns and scrolls them right-to-left across five digits.
// Optional feature: define SEG_SCROLL_WRAP_EN to loop the message forever instead of stopping.
module seg_scroll_ctrl #(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       wr_valid,
  input  logic [6:0] wr_seg,
  output logic       wr_ready,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [6:0] display_out_1,
  output logic [6:0] display_out_2,
  output logic [6:0] display_out_3,
  output logic [6:0] display_out_4,
  output logic [6:0] display_out_5
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH + 5);
  localparam int TW = $clog2(STEP_CYCLES + 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SCROLL = 1'b1;
  localparam logic [6:0] BLANK    = 7'h7F;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_q, done_d;
  logic [6:0]    msg_q [DEPTH];
  logic [6:0]    msg_d [DEPTH];
  logic [6:0]    disp_q [5];
  logic [6:0]    disp_d [5];
  logic          wr_fire;

  assign wr_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  assign wr_fire  = wr_valid && wr_ready;
  assign busy     = (state_q == S_SCROLL);
  assign done     = done_q;

  assign display_out_1 = disp_q[0];
  assign display_out_2 = disp_q[1];
  assign display_out_3 = disp_q[2];
  assign display_out_4 = disp_q[3];
  assign display_out_5 = disp_q[4];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pos_d   = pos_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    msg_d   = msg_q;
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      pos_d   = '0;
      timer_d = '0;
    end else if (state_q == S_IDLE) begin
      if (wr_fire) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (int'(count_q) == i) msg_d[i] = wr_seg;
        end
        count_d = count_q + 1'b1;
      end
      // count_d already includes a same-cycle write, so it joins this scroll
      if (start && (count_d != '0)) begin
        state_d = S_SCROLL;
        pos_d   = '0;
        timer_d = '0;
      end
    end else begin
      if (timer_q == TW'(STEP_CYCLES - 1)) begin
        timer_d = '0;
        if (pos_q == PW'(count_q) + PW'(3)) begin
`ifdef SEG_SCROLL_WRAP_EN
          pos_d = '0;
`else
          pos_d   = PW'(count_q) + PW'(4);
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Displays are computed from next-state values so they track pos on the same edge.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      disp_d[k] = BLANK;
      if (state_d == S_SCROLL) begin
        for (int j = 0; j < DEPTH; j++) begin
          if ((int'(pos_d) + k - 4 == j) && (j < int'(count_d))) disp_d[k] = msg_d[j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pos_q   <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < 5; k++) disp_q[k] <= BLANK;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pos_q   <= pos_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      for (int k = 0; k < 5; k++) disp_q[k] <= disp_d[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) msg_q[i] <= msg_d[i];
  end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed bench for seg_scroll_ctrl: vector table on a DEPTH=4/STEP=2 instance, plus
// hand sequences for full buffer, reset abort and a STEP=1 single-character instance.
module tb_seg_scroll_ctrl;

  localparam logic [6:0] B = 7'h7F;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       clear, wr_valid, start;
  logic [6:0] wr_seg;
  logic       wr_ready, busy, done;
  logic [6:0] d1, d2, d3, d4, d5;

  logic       b_clear, b_wr_valid, b_start;
  logic [6:0] b_wr_seg;
  logic       b_wr_ready, b_busy, b_done;
  logic [6:0] b_d1, b_d2, b_d3, b_d4, b_d5;

  seg_scroll_ctrl #(.DEPTH(4), .STEP_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .wr_valid(wr_valid), .wr_seg(wr_seg),
    .wr_ready(wr_ready), .start(start), .busy(busy), .done(done),
    .display_out_1(d1), .display_out_2(d2), .display_out_3(d3),
    .display_out_4(d4), .display_out_5(d5));

  seg_scroll_ctrl #(.DEPTH(4), .STEP_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear), .wr_valid(b_wr_valid), .wr_seg(b_wr_seg),
    .wr_ready(b_wr_ready), .start(b_start), .busy(b_busy), .done(b_done),
    .display_out_1(b_d1), .display_out_2(b_d2), .display_out_3(b_d3),
    .display_out_4(b_d4), .display_out_5(b_d5));

  typedef struct {
    logic        clr, wv, st;
    logic [6:0]  seg;
    logic [37:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [37:0] pk(logic rdy, logic bsy, logic dn, logic [6:0] e1,
                                     logic [6:0] e2, logic [6:0] e3, logic [6:0] e4,
                                     logic [6:0] e5);
    return {rdy, bsy, dn, e1, e2, e3, e4, e5};
  endfunction

  function automatic void add(logic clr, logic wv, logic [6:0] seg, logic st, logic [37:0] e);
    vec_t v;
    v.clr = clr; v.wv = wv; v.seg = seg; v.st = st; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic logic [37:0] act_a();
    return {wr_ready, busy, done, d1, d2, d3, d4, d5};
  endfunction

  function automatic logic [37:0] act_b();
    return {b_wr_ready, b_busy, b_done, b_d1, b_d2, b_d3, b_d4, b_d5};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clear = 0; wr_valid = 0; start = 0; wr_seg = 7'h00;
    b_clear = 0; b_wr_valid = 0; b_start = 0; b_wr_seg = 7'h00;
  endtask

  initial begin
    int         done_cyc;
    logic       hit;
    logic [6:0] ed [5];
    logic [37:0] e;

    idle_inputs();
    reset = 1'b1;

    // Non-wrap scroll of 40,79, replay, clear, simultaneous write+start, full buffer
    add(0,0,7'h00,0, pk(1,0,0, B,B,B,B,B));
    add(0,1,7'h40,0, pk(1,0,0, B,B,B,B,B));
    add(0,1,7'h79,0, pk(1,0,0, B,B,B,B,B));
    add(0,0,7'h00,1, pk(0,1,0, B,B,B,B,7'h40));
    add(0,0,7'h00,0, pk(0,1,0, B,B,B,B,7'h40));
    add(0,0,7'h00,0, pk(0,1,0, B,B,B,7'h40,7'h79));
    add(0,1,7'h11,1, pk(0,1,0, B,B,B,7'h40,7'h79));
    add(0,0,7'h00,0, pk(0,1,0, B,B,7'h40,7'h79,B));
    add(0,0,7'h00,0, pk(0,1,0, B,B,7'h40,7'h79,B));
    add(0,0,7'h00,0, pk(0,1,0, B,7'h40,7'h79,B,B));
    add(0,0,7'h00,0, pk(0,1,0, B,7'h40,7'h79,B,B));
    add(0,0,7'h00,0, pk(0,1,0, 7'h40,7'h79,B,B,B));
    add(0,0,7'h00,0, pk(0,1,0, 7'h40,7'h79,B,B,B));
    add(0,0,7'h00,0, pk(0,1,0, 7'h79,B,B,B,B));
    add(0,0,7'h00,0, pk(0,1,0, 7'h79,B,B,B,B));
    add(0,0,7'h00,0, pk(1,0,1, B,B,B,B,B));
    add(0,0,7'h00,0, pk(1,0,0, B,B,B,B,B));
    add(0,0,7'h00,1, pk(0,1,0, B,B,B,B,7'h40));
    add(1,0,7'h00,0, pk(1,0,0, B,B,B,B,B));
    add(0,0,7'h00,1, pk(1,0,0, B,B,B,B,B));
    add(0,1,7'h12,1, pk(0,1,0, B,B,B,B,7'h12));
    add(0,0,7'h00,0, pk(0,1,0, B,B,B,B,7'h12));
    add(0,0,7'h00,0, pk(0,1,0, B,B,B,7'h12,B));
    add(0,0,7'h00,1, pk(0,1,0, B,B,B,7'h12,B));
    add(0,0,7'h00,0, pk(0,1,0, B,B,7'h12,B,B));
    add(1,1,7'h55,1, pk(1,0,0, B,B,B,B,B));
    add(0,0,7'h00,1, pk(1,0,0, B,B,B,B,B));
    add(0,1,7'h01,0, pk(1,0,0, B,B,B,B,B));
    add(0,1,7'h02,0, pk(1,0,0, B,B,B,B,B));
    add(0,1,7'h04,0, pk(1,0,0, B,B,B,B,B));
    add(0,1,7'h08,0, pk(0,0,0, B,B,B,B,B));
    add(0,1,7'h00,0, pk(0,0,0, B,B,B,B,B));
    add(0,0,7'h00,1, pk(0,1,0, B,B,B,B,7'h01));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", act_a(), pk(1,0,0, B,B,B,B,B));
    chk("reset_b", act_b(), pk(1,0,0, B,B,B,B,B));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].clr; wr_valid = vecs[i].wv; wr_seg = vecs[i].seg; start = vecs[i].st;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), act_a(), vecs[i].exp);
    end
    idle_inputs();

    // Full buffer: the dropped 5th pattern (00) must never show; done 16 cycles after start
    done_cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      hit = (d1 == 7'h00) || (d2 == 7'h00) || (d3 == 7'h00) || (d4 == 7'h00) || (d5 == 7'h00);
      chk($sformatf("no_5th_c%0d", c), hit, 0);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    chk("full_done_latency", done_cyc, 16);

    // Reset mid-scroll aborts without done
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    chk("replay_start", act_a(), pk(0,1,0, B,B,B,B,7'h01));
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("reset_mid", act_a(), pk(1,0,0, B,B,B,B,B));
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset_c%0d", c), act_a(), pk(1,0,0, B,B,B,B,B));
    end

    // Single character, STEP_CYCLES=1, written together with start
    b_wr_valid = 1; b_wr_seg = 7'h3F; b_start = 1;
    @(posedge clk);
    #1;
    b_wr_valid = 0; b_start = 0;
    chk("b_entry", act_b(), pk(0,1,0, B,B,B,B,7'h3F));
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) ed[k] = B;
`ifdef SEG_SCROLL_WRAP_EN
      ed[4 - (c % 5)] = 7'h3F;
      e = pk(0,1,0, ed[0],ed[1],ed[2],ed[3],ed[4]);
`else
      if (c <= 4) begin
        ed[4 - c] = 7'h3F;
        e = pk(0,1,0, ed[0],ed[1],ed[2],ed[3],ed[4]);
      end else begin
        e = pk(1,0,(c == 5), B,B,B,B,B);
      end
`endif
      chk($sformatf("b_c%0d", c), act_b(), e);
    end

    b_clear = 1;
    @(posedge clk);
    #1;
    b_clear = 0;
    chk("b_clear", act_b(), pk(1,0,0, B,B,B,B,B));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
